// File: rtl/pipe_spawner.sv
// Pipe spawner: decides when the next pipe launches and where its gap centre sits.
// Emits a one-tick spawnPulse (feeds the pipe stage's mouse1) with a registered pointY
// drawn from a 16-bit Galois LFSR. The delay between pipes shrinks with score down to a
// floor, and a watchdog re-arms the spawner if endOfMapPipe never arrives.
// Optional build macro: PIPE_SPAWN_SMOOTH_EN limits the pointY step between spawns.
module pipe_spawner #(
  parameter logic [15:0] LFSR_SEED         = 16'hACE1,
  parameter int unsigned Y_MIN             = 112,
  parameter int unsigned Y_RESET           = 240,
  parameter int unsigned BASE_GAP_TICKS    = 40,
  parameter int unsigned GAP_DEC_PER_SCORE = 2,
  parameter int unsigned MIN_GAP_TICKS     = 10,
  parameter int unsigned FLY_TIMEOUT       = 1023,
  parameter int unsigned MAX_STEP          = 64
) (
  input  logic       animationCLOCK,
  input  logic       nRESET,
  input  logic       gameRunning,
  input  logic [9:0] score,
  input  logic       endOfMapPipe,
  output logic       spawnPulse,
  output logic [9:0] pointY,
  output logic [9:0] spawnCount,
  output logic       spawnerBusy
);

`ifdef PIPE_SPAWN_SMOOTH_EN
  localparam bit SmoothEn = 1'b1;
`else
  localparam bit SmoothEn = 1'b0;
`endif

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWaitGap = 2'd1;
  localparam logic [1:0] StSpawn   = 2'd2;
  localparam logic [1:0] StFlying  = 2'd3;

  localparam logic signed [10:0] StepS = 11'(MAX_STEP);

  logic [1:0]  state_q, state_d;
  logic [9:0]  timer_q, timer_d;
  logic [9:0]  pointy_q, pointy_d;
  logic [9:0]  count_q, count_d;
  logic [15:0] lfsr_q, lfsr_d;

  logic [19:0] prod;
  logic [9:0]  gap;
  logic [9:0]  raw_y;
  logic [9:0]  new_y;
  logic signed [10:0] raw_s, hi_s, lo_s;

  // Score-scaled inter-pipe delay; the compare happens before the subtract so it never wraps.
  always_comb begin
    prod = {10'd0, score} * 20'(GAP_DEC_PER_SCORE);
    if (prod >= 20'(BASE_GAP_TICKS - MIN_GAP_TICKS)) begin
      gap = 10'(MIN_GAP_TICKS);
    end else begin
      gap = 10'(20'(BASE_GAP_TICKS) - prod);
    end
  end

  // Galois LFSR, taps x^16+x^14+x^13+x^11+1, shifting right.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Candidate gap centre, optionally clamped to within MAX_STEP of the current one.
  always_comb begin
    raw_y = 10'(Y_MIN) + {2'b00, lfsr_q[7:0]};
    raw_s = signed'({1'b0, raw_y});
    hi_s  = signed'({1'b0, pointy_q}) + StepS;
    lo_s  = signed'({1'b0, pointy_q}) - StepS;
    new_y = raw_y;
    if (SmoothEn && (raw_s > hi_s)) begin
      new_y = hi_s[9:0];
    end else if (SmoothEn && (raw_s < lo_s)) begin
      new_y = lo_s[9:0];
    end
  end

  // Next-state logic; dropping gameRunning overrides every other event.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pointy_d = pointy_q;
    count_d  = count_q;
    if (!gameRunning) begin
      state_d = StIdle;
      timer_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          timer_d = gap;
          count_d = '0;
          state_d = StWaitGap;
        end
        StWaitGap: begin
          if (timer_q == '0) begin
            pointy_d = new_y;
            state_d  = StSpawn;
          end else begin
            timer_d = timer_q - 10'd1;
          end
        end
        StSpawn: begin
          count_d = count_q + 10'd1;
          timer_d = 10'(FLY_TIMEOUT);
          state_d = StFlying;
        end
        StFlying: begin
          // Timer expiry recovers from a lost endOfMapPipe pulse.
          if (endOfMapPipe || (timer_q == '0)) begin
            timer_d = gap;
            state_d = StWaitGap;
          end else begin
            timer_d = timer_q - 10'd1;
          end
        end
        default: begin
          state_d = StIdle;
          timer_d = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge animationCLOCK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      pointy_q <= 10'(Y_RESET);
      count_q  <= '0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pointy_q <= pointy_d;
      count_q  <= count_d;
      lfsr_q   <= lfsr_d;
    end
  end

  // Outputs; the pulse is gated so a game stop kills it within the same tick.
  always_comb begin
    spawnPulse  = (state_q == StSpawn) && gameRunning;
    spawnerBusy = (state_q == StFlying);
    pointY      = pointy_q;
    spawnCount  = count_q;
  end

endmodule
